// File: rtl/cnn_load_pkg.sv
// Shared types and parameter defaults for the row stream loader.
package cnn_load_pkg;

  localparam int unsigned DEF_DW          = 32;
  localparam int unsigned DEF_ROW_LEN     = 32;
  localparam int unsigned DEF_ROWS        = 32;
  localparam int unsigned DEF_AW          = 10;
  localparam int unsigned DEF_ROM_LAT     = 1;
  localparam int unsigned DEF_NUM_SAMPLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRESENT
  } load_state_e;

  // Index width that stays legal for a modulus of 1.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_lat_pipe.sv
// Read-strobe delay line matching the ROM latency; flush drops every in-flight read.
module rom_lat_pipe #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = vld_i;
    for (int unsigned i = 1; i < LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (flush_i) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_o = sr_q[LAT-1];

endmodule

// File: rtl/row_stream_loader.sv
// Streams ROWS rows of ROW_LEN ROM words per sample into a wide row register,
// presenting each row with a valid/ready handshake.
module row_stream_loader
  import cnn_load_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned ROW_LEN     = DEF_ROW_LEN,
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned ROM_LAT     = DEF_ROM_LAT,
  parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          en,
  input  logic                          next_sample,
  output logic                          rom_rd,
  output logic [AW-1:0]                 rom_addr,
  input  logic [DW-1:0]                 rom_data,
  output logic [DW*ROW_LEN-1:0]         row_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [width_of(ROWS)-1:0]     row_idx,
  output logic                          last_row,
  output logic                          done,
  output logic [width_of(NUM_SAMPLES)-1:0] ss,
  output logic                          busy
);

  localparam int unsigned RIW = width_of(ROWS);
  localparam int unsigned SSW = width_of(NUM_SAMPLES);
  localparam int unsigned CW  = $clog2(ROW_LEN + 1);

  if (64'(ROWS) * 64'(ROW_LEN) > (64'd1 << AW)) begin : g_bad_aw
    $error("row_stream_loader: ROWS*ROW_LEN exceeds the ROM address space");
  end
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("row_stream_loader: ROM_LAT must be 1..4");
  end

  load_state_e             state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           cap_cnt_q, cap_cnt_d;
  logic [DW*ROW_LEN-1:0]   row_q, row_d;
  logic [RIW-1:0]          row_idx_q, row_idx_d;
  logic [SSW-1:0]          ss_q, ss_d;
  logic                    done_q, done_d;

  logic rd_issue;
  logic cap_vld;
  logic capture;

  assign rd_issue = (state_q == ST_FETCH) && en && !next_sample;
  // Returns are captured whether or not en is high; only an abort drops them.
  assign capture  = cap_vld && !next_sample &&
                    ((state_q == ST_FETCH) || (state_q == ST_DRAIN));

  rom_lat_pipe #(
    .LAT(ROM_LAT)
  ) u_lat_pipe (
    .clk    (clk),
    .rst    (rst),
    .flush_i(next_sample),
    .vld_i  (rd_issue),
    .vld_o  (cap_vld)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_cnt_d  = rd_cnt_q;
    cap_cnt_d = cap_cnt_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    ss_d      = ss_q;
    done_d    = 1'b0;

    if (capture) begin
      for (int unsigned k = 1; k < ROW_LEN; k++) begin
        row_d[k*DW +: DW] = row_q[(k-1)*DW +: DW];
      end
      row_d[0 +: DW] = rom_data;
      cap_cnt_d      = cap_cnt_q + 1'b1;
    end

    if (rd_issue) begin
      addr_d   = addr_q + 1'b1;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          addr_d    = '0;
          row_idx_d = '0;
          rd_cnt_d  = '0;
          cap_cnt_d = '0;
        end
      end
      ST_FETCH: begin
        if (rd_issue && (rd_cnt_q == CW'(ROW_LEN - 1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (capture && (cap_cnt_q == CW'(ROW_LEN - 1))) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (row_ready) begin
          if (row_idx_q == RIW'(ROWS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
            rd_cnt_d  = '0;
            cap_cnt_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything decided above, including start and acceptance.
    if (next_sample) begin
      state_d   = ST_IDLE;
      addr_d    = '0;
      row_idx_d = '0;
      rd_cnt_d  = '0;
      cap_cnt_d = '0;
      done_d    = 1'b0;
      ss_d      = (ss_q == SSW'(NUM_SAMPLES - 1)) ? '0 : ss_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      row_q     <= '0;
      row_idx_q <= '0;
      ss_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      row_q     <= row_d;
      row_idx_q <= row_idx_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
    end
  end

  assign rom_rd    = rd_issue;
  assign rom_addr  = addr_q;
  assign row_data  = row_q;
  assign row_valid = (state_q == ST_PRESENT);
  assign row_idx   = row_idx_q;
  assign last_row  = row_valid && (row_idx_q == RIW'(ROWS - 1));
  assign done      = done_q;
  assign ss        = ss_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/row_stream_loader.md
ROW_STREAM_LOADER -- requirements
Module: row_stream_loader

Interface
REQ-001 SHALL have parameter DW, default 32, meaning ROM word width in bits.
REQ-002 SHALL have parameter ROW_LEN, default 32, meaning words per row.
REQ-003 SHALL have parameter ROWS, default 32, meaning rows per sample.
REQ-004 SHALL have parameter AW, default 10, meaning ROM address width.
REQ-005 SHALL have parameter ROM_LAT, default 1 (range 1..4), meaning ROM read latency in cycles.
REQ-006 SHALL have parameter NUM_SAMPLES, default 16, meaning sample index modulus.
REQ-007 SHALL have ports, one per line:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous, active-low reset
  start  in  1  begin loading the current sample (level-sampled in IDLE)
  en  in  1  fetch enable; low pauses new ROM reads
  next_sample  in  1  single-cycle pulse: abort, advance sample index
  rom_rd  out  1  read strobe; rom_addr valid when high
  rom_addr  out  AW  ROM read address
  rom_data  in  DW  ROM data, ROM_LAT cycles after rom_rd
  row_data  out  DW*ROW_LEN  row; element k at bits [k*DW +: DW]
  row_valid  out  1  row_data complete and stable
  row_ready  in  1  consumer accepts row when high with row_valid
  row_idx  out  clog2(ROWS)  index of presented row
  last_row  out  1  high with row_valid when row_idx==ROWS-1
  done  out  1  one-cycle pulse after last row accepted
  ss  out  clog2(NUM_SAMPLES)  current sample index
  busy  out  1  high in any state other than IDLE

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, DRAIN, PRESENT.
REQ-009 IDLE: start=1 SHALL move to FETCH, clear row_idx, set rom_addr=0.
REQ-010 FETCH: each cycle with en=1 SHALL assert rom_rd and post-increment rom_addr; en=0 SHALL hold rom_addr, rom_rd=0.
REQ-011 After ROW_LEN reads issued, SHALL move to DRAIN; DRAIN SHALL wait until all ROW_LEN words captured.
REQ-012 Capture: rom_rd delayed ROM_LAT cycles SHALL shift rom_data into element 0 while element k moves to k+1; first word read ends in element ROW_LEN-1.
REQ-013 In-flight returns SHALL be captured regardless of en.
REQ-014 With en held high, row_valid SHALL assert exactly ROW_LEN+ROM_LAT+1 cycles after the cycle start is sampled.
REQ-015 PRESENT: row_valid=1; row_data, row_idx stable until row_valid&&row_ready.
REQ-016 On acceptance with row_idx<ROWS-1: row_idx+1, return to FETCH next cycle, rom_addr continues linearly (row r words at r*ROW_LEN..r*ROW_LEN+ROW_LEN-1).
REQ-017 On acceptance with row_idx==ROWS-1: pulse done one cycle, go IDLE.
REQ-018 next_sample in any state SHALL: go IDLE, rom_rd=0, row_valid=0, rom_addr=0, row_idx=0, discard in-flight reads, ss=ss+1 wrapping NUM_SAMPLES-1 -> 0.
REQ-019 next_sample SHALL take priority over start and row_ready in the same cycle.
REQ-020 ROWS*ROW_LEN > 2^AW SHALL be an elaboration error; rom_addr never wraps in legal configurations.

Reset
REQ-021 rst low SHALL asynchronously force IDLE, all outputs 0, row_data 0, ss 0, delay line cleared.
REQ-022 Reset mid-operation SHALL discard all in-flight reads; no capture after release.

Structure
REQ-023 FSM state enum and parameter defaults SHALL live in shared package cnn_load_pkg.
REQ-024 ROM_LAT strobe delay line SHALL be sub-module rom_lat_pipe (valid shift register with synchronous flush).

Verification (DW=16, ROW_LEN=4, ROWS=2, ROM_LAT=1, rom_data=address+0x100)
REQ-025 start at cycle 0, en=1, row_ready=1 -> row_valid cycle 6, row_data elements 0..3 = 0x103,0x102,0x101,0x100; second row 0x107..0x104 with last_row=1; done pulses once.
REQ-026 en low 3 cycles after second read -> rom_addr holds 2, rom_rd=0, in-flight word captured, row_valid delayed exactly 3 cycles.
REQ-027 row_ready low 5 cycles in PRESENT -> row_data, row_idx unchanged, no rom_rd until accept.
REQ-028 next_sample during FETCH with read in flight -> IDLE next cycle, ss 0->1, no capture, row_valid stays 0.
REQ-029 ss=15, next_sample -> ss=0; next_sample and start same cycle -> stays IDLE.
REQ-030 rst low during DRAIN -> all outputs 0 immediately; restart yields REQ-025 results.
